// File: rtl/bcd_int.sv
// Sequential BCD-to-binary converter using reverse double-dabble: one right shift
// per cycle, then any BCD nibble >= 8 is reduced by 3. Non-decimal digits are rejected.
module bcd_int #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    convert,
  output logic [BIN_W-1:0]        num,
  output logic                    conv_done,
  output logic                    error,
  output logic                    busy
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int SREG_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE, ERR} state_t;

  state_t              state_reg, state_next;
  logic [SREG_W-1:0]   sreg_reg, sreg_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [BIN_W-1:0]    num_reg, num_next;

  logic [NUM_DIGITS-1:0] digit_bad;
  logic [SREG_W-1:0]     shifted;
  logic [SREG_W-1:0]     adjusted;

  assign shifted = sreg_reg >> 1;
  assign adjusted[BIN_W-1:0] = shifted[BIN_W-1:0];

  // Per-digit validity check on the request and per-nibble correction after each shift.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] nib;
      assign digit_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
      assign nib = shifted[BIN_W + 4*gi +: 4];
      assign adjusted[BIN_W + 4*gi +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sreg_reg  <= '0;
      cnt_reg   <= '0;
      num_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sreg_reg  <= sreg_next;
      cnt_reg   <= cnt_next;
      num_reg   <= num_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sreg_next  = sreg_reg;
    cnt_next   = cnt_reg;
    num_next   = num_reg;
    case (state_reg)
      IDLE: begin
        if (convert) begin
          if (|digit_bad) begin
            state_next = ERR;
          end else begin
            state_next = CONV;
            sreg_next  = {bcd_in, {BIN_W{1'b0}}};
            cnt_next   = '0;
          end
        end
      end
      CONV: begin
        sreg_next = adjusted;
        cnt_next  = cnt_reg + CNT_W'(1);
        // Last shift: the result is captured here so it is valid alongside conv_done.
        if (cnt_reg == CNT_W'(BIN_W - 1)) begin
          state_next = DONE;
          num_next   = adjusted[BIN_W-1:0];
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign num       = num_reg;
  assign conv_done = (state_reg == DONE);
  assign error     = (state_reg == ERR);
  assign busy      = (state_reg == CONV);

endmodule

// File: tb/tb_bcd_int.sv
// Self-checking bench for bcd_int: directed cases plus a random BCD sweep checked
// against a decimal-weight reference model.
module tb_bcd_int;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic        convert;
  logic [13:0] num;
  logic        conv_done;
  logic        error;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;
  int last_num = 0;

  bcd_int #(.NUM_DIGITS(4), .BIN_W(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .convert   (convert),
    .num       (num),
    .conv_done (conv_done),
    .error     (error),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: value is the sum of digit * 10^position.
  function automatic int bcd_val(input logic [15:0] b);
    int v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic bit bcd_bad(input logic [15:0] b);
    bit bad = 0;
    for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) bad = 1;
    return bad;
  endfunction

  task automatic do_conv(input logic [15:0] bcd, input string tag);
    int c;
    int busy_cnt;
    @(negedge clk);
    bcd_in  = bcd;
    convert = 1'b1;
    @(negedge clk);
    convert = 1'b0;
    bcd_in  = 16'($urandom);
    if (bcd_bad(bcd)) begin
      check({tag, " error"}, 32'(error), 32'd1);
      check({tag, " no_done"}, 32'(conv_done), 32'd0);
      check({tag, " num_kept"}, 32'(num), 32'(last_num));
      @(negedge clk);
      check({tag, " error_1cyc"}, 32'(error), 32'd0);
      check({tag, " idle_busy"}, 32'(busy), 32'd0);
      $display("[TB] %s bcd=%h -> error pulse, num=%0d", tag, bcd, num);
    end else begin
      c = 1;
      busy_cnt = 0;
      while (!conv_done && c < 40) begin
        if (busy) busy_cnt++;
        @(negedge clk);
        c++;
      end
      check({tag, " latency"}, 32'(c), 32'd15);
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd14);
      check({tag, " num"}, 32'(num), 32'(bcd_val(bcd)));
      check({tag, " no_err_with_done"}, 32'(error), 32'd0);
      check({tag, " busy_in_done"}, 32'(busy), 32'd0);
      last_num = bcd_val(bcd);
      @(negedge clk);
      check({tag, " done_1cyc"}, 32'(conv_done), 32'd0);
      $display("[TB] %s bcd=%h -> num=%0d latency=%0d", tag, bcd, num, c);
    end
  endtask

  initial begin
    int c;
    int seen;
    int t;
    int d[$];
    logic [15:0] rb;

    rst_n   = 1'b0;
    convert = 1'b0;
    bcd_in  = '0;
    repeat (2) @(negedge clk);
    check("reset num", 32'(num), 32'd0);
    check("reset conv_done", 32'(conv_done), 32'd0);
    check("reset error", 32'(error), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    $display("[TB] reset: num=%0d busy=%0b", num, busy);
    rst_n = 1'b1;

    do_conv(16'h1234, "c1234");
    do_conv(16'h12A4, "bad12A4");
    do_conv(16'h9999, "c9999");
    do_conv(16'h0000, "c0000");
    do_conv(16'h0001, "c0001");
    do_conv(16'hF000, "badF000");

    // Request during conversion is ignored; bcd_in is captured at accept.
    @(negedge clk);
    bcd_in  = 16'h0500;
    convert = 1'b1;
    @(negedge clk);
    convert = 1'b0;
    c = 1;
    repeat (4) begin @(negedge clk); c++; end
    bcd_in  = 16'h0777;
    convert = 1'b1;
    @(negedge clk);
    c++;
    convert = 1'b0;
    while (!conv_done && c < 40) begin @(negedge clk); c++; end
    check("ignore latency", 32'(c), 32'd15);
    check("ignore num", 32'(num), 32'd500);
    $display("[TB] busy-ignore: num=%0d latency=%0d", num, c);
    @(negedge clk);

    // Reset mid-conversion aborts it.
    bcd_in  = 16'h0042;
    convert = 1'b1;
    @(negedge clk);
    convert = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort num", 32'(num), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (conv_done) seen++;
      @(negedge clk);
    end
    check("abort no_done", 32'(seen), 32'd0);
    check("abort num_after", 32'(num), 32'd0);
    last_num = 0;
    $display("[TB] mid-run reset: num=%0d done_pulses=%0d", num, seen);

    // Held convert: back-to-back conversions at the minimum period.
    bcd_in  = 16'h0010;
    convert = 1'b1;
    t = 0;
    while (d.size() < 3 && t < 80) begin
      @(negedge clk);
      t++;
      if (conv_done) begin
        d.push_back(t);
        check("held num", 32'(num), 32'd10);
      end
    end
    convert = 1'b0;
    check("held count", 32'(d.size()), 32'd3);
    if (d.size() == 3) begin
      check("held period1", 32'(d[1] - d[0]), 32'd16);
      check("held period2", 32'(d[2] - d[1]), 32'd16);
      $display("[TB] held convert: done at cycles %0d %0d %0d", d[0], d[1], d[2]);
    end
    last_num = 10;
    @(negedge clk);
    check("held idle busy", 32'(busy), 32'd0);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) rb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      do_conv(rb, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
